pkt_fifo: RTL
=============

Name: pkt_fifo

Overview:
Parametrised packet-aware synchronous FIFO for the router datapath. It is the successor to the fixed 8x16 router FIFO. Each stored word carries a start-of-packet flag next to the data. The read side decodes the header length field and tracks the remaining bytes of the packet in flight, adding almost-full, occupancy count, packet-done and optional error reporting.

Parameters:
DATA_W, 8, data width in bits; stored word is DATA_W+1 bits ({sof, data}).
DEPTH, 16, number of entries; must be a power of two, >= 4.
LEN_LSB, 2, LSB position of the payload-length field in the header word.
LEN_W, 6, width of the payload-length field; LEN_LSB+LEN_W <= DATA_W.
AF_MARGIN, 2, almost_full asserts when count >= DEPTH-AF_MARGIN.

Ports:
clk  in  1  clock; all logic on rising edge.
rst  in  1  synchronous reset, active-high.
soft_rst  in  1  synchronous flush, active-high (per-port timeout flush from router FSM).
wr_en  in  1  write request.
lfd_state  in  1  stored as the sof flag of the word written this cycle.
din  in  DATA_W  write data.
rd_en  in  1  read request.
dout  out  DATA_W  read data, registered.
dout_valid  out  1  dout holds a word read on the previous cycle.
sof_out  out  1  sof flag of the word on dout.
full  out  1  count == DEPTH.
empty  out  1  count == 0.
almost_full  out  1  count >= DEPTH-AF_MARGIN.
count  out  $clog2(DEPTH)+1  occupancy.
pkt_active  out  1  pkt_rem != 0.
pkt_done  out  1  one-cycle pulse when the last byte of a packet is read.
ovf_err  out  1  sticky: write attempted while full.
udf_err  out  1  sticky: read attempted while empty.
trunc_err  out  1  sticky: header read while pkt_rem != 0.

Behaviour:
- Priority: rst > soft_rst > normal operation.
- rst: pointers, count, pkt_rem, dout, dout_valid, sof_out, pkt_done and all error flags are 0. Memory is not reset.
- soft_rst: pointers, count, pkt_rem, dout, dout_valid, sof_out and pkt_done go to 0. Error flags are held. Any wr_en/rd_en in the same cycle is ignored.
- Write accepted iff wr_en && !full. Stores {lfd_state, din} at wr_ptr, then wr_ptr+1 mod DEPTH.
- Read accepted iff rd_en && !empty. rd_ptr+1 mod DEPTH.
- Read latency is 1 cycle. On the cycle after an accepted read, dout/sof_out hold the word and dout_valid=1. With no accepted read, dout_valid=0 and dout/sof_out hold their last value.
- full and empty are decoded from the registered count.
  - Simultaneous wr_en and rd_en when full: the read is accepted, the write is rejected.
  - Simultaneous wr_en and rd_en when empty: the write is accepted, the read is rejected.
  - Otherwise both are accepted and count is unchanged.
- count: +1 on write only, -1 on read only, unchanged on both or neither.
- pkt_rem (LEN_W+1 bits, internal):
  - On an accepted read of a sof=1 word, load len+1, where len = word[LEN_LSB+LEN_W-1:LEN_LSB]. This covers the payload plus the parity byte.
  - On an accepted read of a sof=0 word with pkt_rem != 0, decrement.
  - On a sof=0 read with pkt_rem == 0 (stray word), hold at 0.
- pkt_done is registered and aligned with dout_valid of the word that took pkt_rem from 1 to 0.
- Header with len=0: pkt_rem=1, so the parity byte is the only trailer.
- A header read while pkt_rem != 0 reloads pkt_rem from the new header (the old packet is abandoned).
- Pointer wrap is natural binary rollover; no special case at DEPTH-1.

Optional Feature:
PKT_FIFO_ERR_EN
- Defined: ovf_err, udf_err and trunc_err set on their events, cleared only by rst.
- Undefined: all three are tied 0 and no error logic is synthesised. Ports remain in place.

Test Plan:
- rst=1 for 2 cycles, then idle: empty=1, full=0, count=0, dout_valid=0, all errors 0.
- Write header 0x0C (len=3, lfd_state=1), then 0x11, 0x22, 0x33, parity 0x44; read 5 words: dout 0C,11,22,33,44 on consecutive cycles; pkt_active high from cycle after header read; pkt_done=1 only with 0x44.
- Write 16 words: full=1 at count=16, almost_full from count=14. 17th write: count stays 16, ovf_err=1 with PKT_FIFO_ERR_EN, 0 without.
- Full FIFO with wr_en=rd_en=1: read accepted, write rejected, count=15. Empty FIFO with both: write accepted, dout_valid=0, count=1.
- Write 20 words with interleaved reads to cross wrap: data order preserved through ptr 15->0.
- Mid-packet soft_rst with count=5 and wr_en=1: next cycle count=0, empty=1, pkt_active=0, dout=0, dout_valid=0; next header read loads fresh pkt_rem and trunc_err stays 0.

Source files
------------

// File: rtl/pkt_fifo.sv
// Packet-aware synchronous FIFO: {sof, data} storage, 1-cycle registered read, header length tracking.
// Optional sticky error flags are built only when PKT_FIFO_ERR_EN is defined.
module pkt_fifo #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int LEN_LSB   = 2,
    parameter int LEN_W     = 6,
    parameter int AF_MARGIN = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     soft_rst,
    input  logic                     wr_en,
    input  logic                     lfd_state,
    input  logic [DATA_W-1:0]        din,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        dout,
    output logic                     dout_valid,
    output logic                     sof_out,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     pkt_active,
    output logic                     pkt_done,
    output logic                     ovf_err,
    output logic                     udf_err,
    output logic                     trunc_err
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int REM_W = LEN_W + 1;

    logic [DATA_W:0]     mem_q [DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [REM_W-1:0]    pkt_rem_q, pkt_rem_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic                dout_valid_q, dout_valid_d;
    logic                sof_out_q, sof_out_d;
    logic                pkt_done_q, pkt_done_d;

    logic                wr_acc, rd_acc;
    logic [DATA_W:0]     rd_word;
    logic                rd_sof;
    logic [LEN_W-1:0]    rd_len;

    assign full        = (count_q == CW'(DEPTH));
    assign empty       = (count_q == '0);
    assign almost_full = (count_q >= CW'(DEPTH - AF_MARGIN));

    assign rd_word = mem_q[rd_ptr_q];
    assign rd_sof  = rd_word[DATA_W];
    assign rd_len  = rd_word[LEN_LSB +: LEN_W];

    // A flush swallows any request issued in the same cycle.
    assign wr_acc = wr_en && !full  && !soft_rst;
    assign rd_acc = rd_en && !empty && !soft_rst;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        pkt_rem_d    = pkt_rem_q;
        dout_d       = dout_q;
        sof_out_d    = sof_out_q;
        dout_valid_d = rd_acc;
        pkt_done_d   = 1'b0;
        if (soft_rst) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = '0;
            pkt_rem_d    = '0;
            dout_d       = '0;
            sof_out_d    = 1'b0;
            dout_valid_d = 1'b0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
            if (rd_acc) begin
                rd_ptr_d  = rd_ptr_q + AW'(1);
                dout_d    = rd_word[DATA_W-1:0];
                sof_out_d = rd_sof;
                // Header reload counts payload plus the trailing parity byte.
                if (rd_sof) begin
                    pkt_rem_d = REM_W'(rd_len) + REM_W'(1);
                end else if (pkt_rem_q != '0) begin
                    pkt_rem_d  = pkt_rem_q - REM_W'(1);
                    pkt_done_d = (pkt_rem_q == REM_W'(1));
                end
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc && !rst) mem_q[wr_ptr_q] <= {lfd_state, din};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            pkt_rem_q    <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            sof_out_q    <= 1'b0;
            pkt_done_q   <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            pkt_rem_q    <= pkt_rem_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            sof_out_q    <= sof_out_d;
            pkt_done_q   <= pkt_done_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign sof_out    = sof_out_q;
    assign count      = count_q;
    assign pkt_active = (pkt_rem_q != '0);
    assign pkt_done   = pkt_done_q;

`ifdef PKT_FIFO_ERR_EN
    logic ovf_err_q, ovf_err_d;
    logic udf_err_q, udf_err_d;
    logic trunc_err_q, trunc_err_d;

    // Sticky flags survive a flush; only rst clears them.
    always_comb begin
        ovf_err_d   = ovf_err_q   | (wr_en && full  && !soft_rst);
        udf_err_d   = udf_err_q   | (rd_en && empty && !soft_rst);
        trunc_err_d = trunc_err_q | (rd_acc && rd_sof && (pkt_rem_q != '0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_err_q   <= 1'b0;
            udf_err_q   <= 1'b0;
            trunc_err_q <= 1'b0;
        end else begin
            ovf_err_q   <= ovf_err_d;
            udf_err_q   <= udf_err_d;
            trunc_err_q <= trunc_err_d;
        end
    end

    assign ovf_err   = ovf_err_q;
    assign udf_err   = udf_err_q;
    assign trunc_err = trunc_err_q;
`else
    assign ovf_err   = 1'b0;
    assign udf_err   = 1'b0;
    assign trunc_err = 1'b0;
`endif

endmodule
